// File: rtl/flopr_monitor.sv
// Predicts the next q of a sync-reset register and counts mismatches over CHK_LEN compares.
// Results and err_pulse appear one cycle after the compared edge; there is no backpressure, and start is ignored while busy.
module flopr_monitor #(
    parameter int N       = 64,
    parameter int CHK_LEN = 10,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_reset,
    input  logic [N-1:0]     d_obs,
    input  logic [N-1:0]     q_obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err,
    output logic [N-1:0]     exp_q
);

    typedef enum logic [1:0] {IDLE, PRIME, CHECK, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHK_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] first_err_q, first_err_d;
    logic             err_pulse_q, err_pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N-1:0]     exp_q_q, exp_q_d;
    logic             mismatch;

    // Case inequality so X/Z on the observed q is flagged in simulation.
    assign mismatch = (q_obs !== exp_q_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        err_pulse_d = 1'b0;
        exp_q_d     = exp_q_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = PRIME;
                    cnt_d       = '0;
                    err_count_d = '0;
                    first_err_d = '1;
                end
            end
            PRIME: begin
                exp_q_d = dut_reset ? '0 : d_obs;
                state_d = CHECK;
            end
            CHECK: begin
                exp_q_d = dut_reset ? '0 : d_obs;
                cnt_d   = cnt_q + 1'b1;
                if (mismatch) begin
                    err_pulse_d = 1'b1;
                    if (err_count_q != '1)
                        err_count_d = err_count_q + 1'b1;
                    if (first_err_q == '1)
                        first_err_d = cnt_q;
                end
                if (cnt_q == LAST_IDX)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == PRIME) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_count_q <= '0;
            first_err_q <= '1;
            err_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            exp_q_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            err_pulse_q <= err_pulse_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            exp_q_q     <= exp_q_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = done_q && (err_count_q == '0);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign first_err = first_err_q;
    assign exp_q     = exp_q_q;

endmodule

// File: tb/tb_flopr_monitor.sv
// Directed bench: a behavioural flopr beside the monitor, plus a narrow-counter instance for saturation.
module tb_flopr_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start2;
    logic        dut_reset;
    logic [63:0] d_obs, q_obs, flop_q, exp_q;
    logic        busy, done, pass, err_pulse;
    logic [7:0]  err_count, first_err;
    logic        q_tied, force_b0;

    logic [7:0]  d_obs2, q_obs2, exp_q2;
    logic        busy2, done2, pass2, err_pulse2;
    logic [3:0]  err_count2, first_err2;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int pulse_base;

    always #5 clk = ~clk;

    always_ff @(posedge clk) flop_q <= dut_reset ? 64'd0 : d_obs;
    always @(negedge clk) if (err_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

    assign q_obs  = q_tied ? d_obs : (flop_q | {63'd0, force_b0});
    assign d_obs2 = 8'h00;
    assign q_obs2 = 8'hFF;

    flopr_monitor #(.N(64), .CHK_LEN(10), .CNT_W(8)) u_mon (
        .clk(clk), .reset(reset), .start(start), .dut_reset(dut_reset),
        .d_obs(d_obs), .q_obs(q_obs), .busy(busy), .done(done), .pass(pass),
        .err_pulse(err_pulse), .err_count(err_count), .first_err(first_err), .exp_q(exp_q)
    );

    flopr_monitor #(.N(8), .CHK_LEN(15), .CNT_W(4)) u_mon_sat (
        .clk(clk), .reset(reset), .start(start2), .dut_reset(1'b0),
        .d_obs(d_obs2), .q_obs(q_obs2), .busy(busy2), .done(done2), .pass(pass2),
        .err_pulse(err_pulse2), .err_count(err_count2), .first_err(first_err2), .exp_q(exp_q2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Pulse start for one edge (the IDLE/DONE -> PRIME edge).
    task automatic kick(input logic [63:0] d);
        start = 1'b1;
        d_obs = d;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start2 = 1'b0; dut_reset = 1'b0;
        d_obs = '0; q_tied = 1'b0; force_b0 = 1'b0;
        tick(); tick();

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_cnt", err_count, 0);
        chk("rst_first", first_err, 8'hFF);
        chk("rst_expq", exp_q, 0);
        chk("rst_first2", first_err2, 4'hF);
        reset = 1'b1;
        tick();

        // Clean run with flopr held in reset first, and dut_reset pulsed mid-run.
        dut_reset = 1'b1;
        repeat (5) begin d_obs = rnd64(); tick(); end
        dut_reset = 1'b0;
        kick(rnd64());
        for (int i = 0; i < 10; i++) begin
            d_obs = rnd64();
            dut_reset = (i == 5);
            tick();
            chk("clean_expq", exp_q, (i == 5) ? 64'd0 : d_obs);
        end
        dut_reset = 1'b0;
        chk("clean_busy_pre", busy, 1);
        chk("clean_done_pre", done, 0);
        d_obs = rnd64();
        tick();
        chk("clean_done", done, 1);
        chk("clean_busy", busy, 0);
        chk("clean_cnt", err_count, 0);
        chk("clean_pass", pass, 1);
        chk("clean_first", first_err, 8'hFF);

        // q tied to d: every compare sees the new d, prediction holds the old one.
        q_tied = 1'b1;
        kick(64'd1);
        for (int i = 2; i <= 12; i++) begin
            d_obs = 64'(i);
            tick();
        end
        chk("tied_done", done, 1);
        chk("tied_last_pulse", err_pulse, 1);
        chk("tied_cnt", err_count, 10);
        chk("tied_first", first_err, 0);
        chk("tied_pass", pass, 0);
        tick();
        chk("tied_hold_pulse", err_pulse, 0);
        chk("tied_hold_cnt", err_count, 10);

        // Single injected fault at compare index 4 (edge 7 after start).
        q_tied = 1'b0;
        pulse_base = pulse_cnt;
        kick(rnd64() & ~64'd1);
        for (int t = 2; t <= 12; t++) begin
            d_obs = rnd64() & ~64'd1;
            force_b0 = (t == 7);
            tick();
        end
        force_b0 = 1'b0;
        tick();
        chk("inj_done", done, 1);
        chk("inj_cnt", err_count, 1);
        chk("inj_first", first_err, 4);
        chk("inj_pulses", 64'(pulse_cnt - pulse_base), 1);
        chk("inj_pass", pass, 0);

        // Start during CHECK is ignored; start in DONE restarts with cleared counters.
        q_tied = 1'b1;
        kick(64'd100);
        for (int t = 2; t <= 12; t++) begin
            d_obs = 64'(100 + t);
            start = (t == 6);
            tick();
            if (t == 6) begin
                chk("ign_busy", busy, 1);
                chk("ign_cnt", err_count, 4);
            end
        end
        start = 1'b0;
        chk("ign_done", done, 1);
        chk("ign_cnt_final", err_count, 10);
        q_tied = 1'b0;
        kick(rnd64());
        chk("rst_run_cnt", err_count, 0);
        chk("rst_run_first", first_err, 8'hFF);
        chk("rst_run_busy", busy, 1);
        chk("rst_run_done", done, 0);
        for (int t = 2; t <= 12; t++) begin d_obs = rnd64(); tick(); end
        chk("rst_run_pass", pass, 1);

        // Async reset mid-CHECK after three logged errors.
        q_tied = 1'b1;
        kick(64'd500);
        for (int t = 2; t <= 5; t++) begin d_obs = 64'(500 + t); tick(); end
        chk("abort_pre_cnt", err_count, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cnt", err_count, 0);
        chk("abort_first", first_err, 8'hFF);
        tick();
        reset = 1'b1;
        q_tied = 1'b0;
        tick();
        chk("abort_idle_busy", busy, 0);

        // Narrow counters: 15 mismatches reach all-ones exactly.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (15) tick();
        chk("sat_done_pre", done2, 0);
        tick();
        chk("sat_done", done2, 1);
        chk("sat_cnt", err_count2, 4'hF);
        chk("sat_first", first_err2, 0);
        chk("sat_pass", pass2, 0);
        tick();
        chk("sat_hold", err_count2, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
